// File: rtl/fft_pkg.sv
// Shared constants, bank-occupancy encoding and index helpers for the 8-point FFT datapath.
package fft_pkg;
  localparam int unsigned N_PTS      = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_BOTH   = 2'd2
  } occ_t;

  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction
endpackage

// File: rtl/fft_bank_reg.sv
// One 8-bin complex frame register with a single-cycle parallel load and a combinational read mux.
module fft_bank_reg
  import fft_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [N_PTS-1:0][DW-1:0]  i_re,
  input  logic [N_PTS-1:0][DW-1:0]  i_im,
  input  logic [IDX_W-1:0]          i_rd_idx,
  output logic [DW-1:0]             o_rd_re,
  output logic [DW-1:0]             o_rd_im
);
  logic [N_PTS-1:0][DW-1:0] r_re;
  logic [N_PTS-1:0][DW-1:0] r_im;

  // Frame contents need no reset: occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_re <= i_re;
      r_im <= i_im;
    end
  end

  assign o_rd_re = r_re[i_rd_idx];
  assign o_rd_im = r_im[i_rd_idx];
endmodule

// File: rtl/fft_p2s_out.sv
// Parallel-to-serial FFT output stage: ping-pong frame banks drained one complex bin per beat.
module fft_p2s_out
  import fft_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned ORDER = 0,
  parameter int unsigned SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DW-1:0]     X_0_re,
  input  logic [DW-1:0]     X_1_re,
  input  logic [DW-1:0]     X_2_re,
  input  logic [DW-1:0]     X_3_re,
  input  logic [DW-1:0]     X_4_re,
  input  logic [DW-1:0]     X_5_re,
  input  logic [DW-1:0]     X_6_re,
  input  logic [DW-1:0]     X_7_re,
  input  logic [DW-1:0]     X_0_im,
  input  logic [DW-1:0]     X_1_im,
  input  logic [DW-1:0]     X_2_im,
  input  logic [DW-1:0]     X_3_im,
  input  logic [DW-1:0]     X_4_im,
  input  logic [DW-1:0]     X_5_im,
  input  logic [DW-1:0]     X_6_im,
  input  logic [DW-1:0]     X_7_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);
  logic [N_PTS-1:0][DW-1:0] w_x_re;
  logic [N_PTS-1:0][DW-1:0] w_x_im;

  occ_t              r_occ, w_occ_nxt;
  logic              r_act_sel, w_act_sel_nxt;
  logic [IDX_W-1:0]  r_beat, w_beat_nxt, w_beat_inc, w_rd_idx_act;
  logic              r_load_ready;
  logic              r_out_valid, w_valid_nxt;
  logic [DW-1:0]     r_out_re, w_re_nxt;
  logic [DW-1:0]     r_out_im, w_im_nxt;
  logic [IDX_W-1:0]  r_out_idx, w_idx_nxt;
  logic              r_out_last, w_last_nxt;
  logic              w_load, w_acc, w_last_acc;
  logic [1:0]        w_we;
  logic [IDX_W-1:0]  w_bank_idx [2];
  logic [DW-1:0]     w_bank_re  [2];
  logic [DW-1:0]     w_bank_im  [2];

  assign w_x_re = {X_7_re, X_6_re, X_5_re, X_4_re, X_3_re, X_2_re, X_1_re, X_0_re};
  assign w_x_im = {X_7_im, X_6_im, X_5_im, X_4_im, X_3_im, X_2_im, X_1_im, X_0_im};

  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] b);
    return (ORDER != 0) ? bitrev3(b) : b;
  endfunction

  function automatic logic [DW-1:0] ashr(input logic [DW-1:0] x);
    return DW'($signed(x) >>> SHIFT);
  endfunction

  assign w_beat_inc   = r_beat + 3'd1;
  assign w_rd_idx_act = map_idx(w_beat_inc);

  // Active bank looks one beat ahead; the pending bank always offers bin 0 for promotion.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign w_bank_idx[g] = (r_act_sel == 1'(g)) ? w_rd_idx_act : '0;
    fft_bank_reg #(.DW(DW)) u_bank (
      .clk      (clk),
      .i_we     (w_we[g]),
      .i_re     (w_x_re),
      .i_im     (w_x_im),
      .i_rd_idx (w_bank_idx[g]),
      .o_rd_re  (w_bank_re[g]),
      .o_rd_im  (w_bank_im[g])
    );
  end

  always_comb begin
    w_load        = load_valid && r_load_ready;
    w_acc         = r_out_valid && out_ready;
    w_last_acc    = w_acc && (r_beat == IDX_W'(N_PTS - 1));
    w_occ_nxt     = r_occ;
    w_act_sel_nxt = r_act_sel;
    w_beat_nxt    = r_beat;
    w_valid_nxt   = r_out_valid;
    w_re_nxt      = r_out_re;
    w_im_nxt      = r_out_im;
    w_idx_nxt     = r_out_idx;
    w_last_nxt    = r_out_last;
    w_we          = '0;

    if (w_load) begin
      if (r_occ == OCC_EMPTY || (r_occ == OCC_ACTIVE && w_last_acc))
        w_we[r_act_sel] = 1'b1;
      else
        w_we[!r_act_sel] = 1'b1;
    end

    if (w_last_acc) begin
      w_beat_nxt = '0;
      w_idx_nxt  = '0;
      w_last_nxt = 1'b0;
      if (r_occ == OCC_BOTH) begin
        w_occ_nxt     = OCC_ACTIVE;
        w_act_sel_nxt = !r_act_sel;
        w_re_nxt      = ashr(w_bank_re[!r_act_sel]);
        w_im_nxt      = ashr(w_bank_im[!r_act_sel]);
      end else if (w_load) begin
        // Frame arriving on the release edge is presented straight from the inputs.
        w_occ_nxt = OCC_ACTIVE;
        w_re_nxt  = ashr(w_x_re[0]);
        w_im_nxt  = ashr(w_x_im[0]);
      end else begin
        w_occ_nxt   = OCC_EMPTY;
        w_valid_nxt = 1'b0;
      end
    end else begin
      if (w_acc) begin
        w_beat_nxt = w_beat_inc;
        w_idx_nxt  = w_rd_idx_act;
        w_last_nxt = (w_beat_inc == IDX_W'(N_PTS - 1));
        w_re_nxt   = ashr(w_bank_re[r_act_sel]);
        w_im_nxt   = ashr(w_bank_im[r_act_sel]);
      end
      if (w_load) begin
        if (r_occ == OCC_EMPTY) begin
          w_occ_nxt   = OCC_ACTIVE;
          w_beat_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = '0;
          w_last_nxt  = 1'b0;
          w_re_nxt    = ashr(w_x_re[0]);
          w_im_nxt    = ashr(w_x_im[0]);
        end else begin
          w_occ_nxt = OCC_BOTH;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ        <= OCC_EMPTY;
      r_act_sel    <= 1'b0;
      r_beat       <= '0;
      r_load_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_re     <= '0;
      r_out_im     <= '0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_occ        <= w_occ_nxt;
      r_act_sel    <= w_act_sel_nxt;
      r_beat       <= w_beat_nxt;
      r_load_ready <= (w_occ_nxt != OCC_BOTH);
      r_out_valid  <= w_valid_nxt;
      r_out_re     <= w_re_nxt;
      r_out_im     <= w_im_nxt;
      r_out_idx    <= w_idx_nxt;
      r_out_last   <= w_last_nxt;
    end
  end

  assign load_ready = r_load_ready;
  assign out_valid  = r_out_valid;
  assign out_re     = r_out_re;
  assign out_im     = r_out_im;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;
endmodule

// File: tb/tb_fft_p2s_out.sv
// Scoreboard bench: three instances (natural, bit-reversed, SHIFT=2) share one stimulus stream.
module tb_fft_p2s_out;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] x_re [8];
  logic [15:0] x_im [8];

  logic        d_load_ready [NDUT];
  logic        d_valid      [NDUT];
  logic        d_last       [NDUT];
  logic [15:0] d_re         [NDUT];
  logic [15:0] d_im         [NDUT];
  logic [2:0]  d_idx        [NDUT];

  exp_t sb [NDUT][$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fft_p2s_out #(.DW(16), .ORDER(g == 1 ? 1 : 0), .SHIFT(g == 2 ? 2 : 0)) u_dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(d_load_ready[g]),
      .X_0_re(x_re[0]), .X_1_re(x_re[1]), .X_2_re(x_re[2]), .X_3_re(x_re[3]),
      .X_4_re(x_re[4]), .X_5_re(x_re[5]), .X_6_re(x_re[6]), .X_7_re(x_re[7]),
      .X_0_im(x_im[0]), .X_1_im(x_im[1]), .X_2_im(x_im[2]), .X_3_im(x_im[3]),
      .X_4_im(x_im[4]), .X_5_im(x_im[5]), .X_6_im(x_im[6]), .X_7_im(x_im[7]),
      .out_valid(d_valid[g]), .out_ready(out_ready), .out_re(d_re[g]), .out_im(d_im[g]),
      .out_idx(d_idx[g]), .out_last(d_last[g])
    );
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
  endtask

  function automatic logic [15:0] shr(input logic [15:0] x, input int s);
    logic signed [15:0] v;
    v = x;
    return v >>> s;
  endfunction

  task automatic push_expect();
    logic [2:0] br [8];
    exp_t e;
    int sel;
    br = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < 8; b++) begin
        sel    = (d == 1) ? int'(br[b]) : b;
        e.re   = shr(x_re[sel], (d == 2) ? 2 : 0);
        e.im   = shr(x_im[sel], (d == 2) ? 2 : 0);
        e.idx  = 3'(sel);
        e.last = (b == 7);
        sb[d].push_back(e);
      end
    end
  endtask

  task automatic set_base();
    for (int k = 0; k < 8; k++) begin
      x_re[k] = 16'(k * 100);
      x_im[k] = 16'(-k);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic load_frame();
    bit ok;
    ok = 0;
    push_expect();
    load_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (d_load_ready[0]) ok = 1;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL load_timeout: load_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      done = (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d samples still expected, required 0", sb[0].size());
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check("idle_valid", d, 32'(d_valid[d]), 32'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      for (int d = 0; d < NDUT; d++) begin
        if (d_valid[d]) begin
          if (sb[d].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_sample dut%0d: got idx %0d re %0h, required no sample", d, d_idx[d], d_re[d]);
          end else begin
            e = sb[d][0];
            check("out_re", d, 32'(d_re[d]), 32'(e.re));
            check("out_im", d, 32'(d_im[d]), 32'(e.im));
            check("out_idx", d, 32'(d_idx[d]), 32'(e.idx));
            check("out_last", d, 32'(d_last[d]), 32'(e.last));
            if (out_ready) void'(sb[d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    set_base();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("rst_valid", d, 32'(d_valid[d]), 32'd0);
      check("rst_load_ready", d, 32'(d_load_ready[d]), 32'd1);
      check("rst_re", d, 32'(d_re[d]), 32'd0);
      check("rst_idx", d, 32'(d_idx[d]), 32'd0);
      check("rst_last", d, 32'(d_last[d]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Single frame: natural, bit-reversed and shifted views in parallel.
    check("pre_load_valid", 0, 32'(d_valid[0]), 32'd0);
    load_frame();
    for (int d = 0; d < NDUT; d++) check("latency_valid", d, 32'(d_valid[d]), 32'd1);
    wait_drain();

    // Back-to-back frames A and B.
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin x_re[k] = 16'(1000 + k); x_im[k] = 16'(-1000 - k); end
    load_frame();
    for (int k = 0; k < 8; k++) begin x_re[k] = 16'h7FF0 - 16'(k); x_im[k] = 16'h8000 + 16'(k * 3); end
    load_frame();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("b2b_valid", k, 32'(d_valid[0]), (k < 15) ? 32'd1 : 32'd0);
      check("b2b_load_ready", k, 32'(d_load_ready[0]), (k >= 7) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Stalls with out_ready pattern 1,0,0,1 across two queued frames.
    @(posedge clk); #1;
    fork
      begin
        set_base();
        load_frame();
        for (int k = 0; k < 8; k++) begin x_re[k] = 16'(-300 * k); x_im[k] = 16'(77 * k); end
        load_frame();
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    wait_drain();

    // Shift boundary: most-negative word and -1.
    @(posedge clk); #1;
    set_base();
    x_re[3] = 16'h8000;
    x_im[5] = 16'hFFFF;
    load_frame();
    wait_drain();

    // Reset at beat 4 with the pending bank full.
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin x_re[k] = 16'(5000 + k); x_im[k] = 16'(k); end
    load_frame();
    for (int k = 0; k < 8; k++) begin x_re[k] = 16'(6000 + k); x_im[k] = 16'(-k); end
    load_frame();
    repeat (3) @(posedge clk);
    #1;
    check("pend_full_load_ready", 0, 32'(d_load_ready[0]), 32'd0);
    check("beat4_idx", 0, 32'(d_idx[0]), 32'd4);
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("mid_rst_valid", d, 32'(d_valid[d]), 32'd0);
      check("mid_rst_load_ready", d, 32'(d_load_ready[d]), 32'd1);
      check("mid_rst_last", d, 32'(d_last[d]), 32'd0);
      sb[d].delete();
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 0, 32'(d_valid[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin x_re[k] = 16'(-7 * k - 1); x_im[k] = 16'(900 + k); end
    load_frame();
    check("post_rst_first_idx", 0, 32'(d_idx[0]), 32'd0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
